// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle for the bit-serial add/subtract sequencer.
// master drives the request side; slave is the sequencer itself.
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b, cin,
    input  ready, busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b, cin,
    output ready, busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit add/subtract: one full-adder cell walks the operands
// LSB-first, one bit per clock, with a registered carry between bits.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  serial_add_ctrl_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic             cout_q, ovf_q;
  logic [CntW-1:0]  cnt_q;

  logic             si, couti;
  logic             last_bit;
  logic [WIDTH:0]   res_shift;
  logic [WIDTH-1:0] res_next;
  logic             ready, busy, done;

  // The single full-adder cell; operands are shifted so bit 0 is always current.
  always_comb begin
    si    = a_q[0] ^ b_q[0] ^ carry_q;
    couti = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
  end

  assign last_bit  = (cnt_q == CntW'(WIDTH - 1));
  assign res_shift = {si, res_q};
  assign res_next  = res_shift[WIDTH:1];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun:   if (last_bit) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode
  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    case (state_q)
      StIdle:  ready = 1'b1;
      StRun:   busy  = 1'b1;
      StDone:  done  = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // Datapath; results are published only on the final bit so sum stays stable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            a_q     <= bus.a;
            b_q     <= bus.b ^ {WIDTH{bus.sub}};
            carry_q <= bus.sub | bus.cin;
            cnt_q   <= '0;
          end
        end
        StRun: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= couti;
          cnt_q   <= cnt_q + CntW'(1);
          res_q   <= res_next;
          if (last_bit) begin
            sum_q  <= res_next;
            cout_q <= couti;
            ovf_q  <= carry_q ^ couti;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready = ready;
  assign bus.busy  = busy;
  assign bus.done  = done;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Randomised and directed checks of serial_add_ctrl at WIDTH=8 and WIDTH=1
// against an arithmetic reference model.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(8)) bus8 ();
  serial_add_ctrl_if #(.WIDTH(1)) bus1 ();

  serial_add_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  serial_add_ctrl #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns {ovf, cout, sum[63:0]} for a w-bit add/subtract.
  function automatic logic [65:0] model(input int unsigned w, input logic s,
                                        input logic [63:0] x, input logic [63:0] y,
                                        input logic c);
    logic [63:0] mask, bb, sm;
    logic [64:0] full;
    logic        co, ov;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    bb   = (s ? ~y : y) & mask;
    full = {1'b0, x & mask} + {1'b0, bb} + {64'd0, (s | c)};
    sm   = full[63:0] & mask;
    co   = full[w];
    ov   = (x[w-1] == bb[w-1]) && (sm[w-1] != x[w-1]);
    return {ov, co, sm};
  endfunction

  task automatic run8(input logic s, input logic [7:0] x, input logic [7:0] y, input logic c);
    logic [65:0] m;
    int lat;
    m = model(8, s, {56'd0, x}, {56'd0, y}, c);
    @(negedge clk);
    check("ready8", bus8.ready, 1);
    bus8.start = 1'b1; bus8.sub = s; bus8.a = x; bus8.b = y; bus8.cin = c;
    @(negedge clk);
    // Scramble inputs: they must have no effect once accepted.
    bus8.start = 1'b0;
    bus8.a = 8'($urandom); bus8.b = 8'($urandom);
    bus8.cin = 1'($urandom); bus8.sub = 1'($urandom);
    check("busy8", bus8.busy, 1);
    lat = 0;
    while (!bus8.done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("lat8", lat, 8);
    check("sum8", bus8.sum, m[7:0]);
    check("cout8", bus8.cout, m[64]);
    check("ovf8", bus8.ovf, m[65]);
    @(negedge clk);
    check("pulse8", bus8.done, 0);
    check("ready8_ret", bus8.ready, 1);
  endtask

  task automatic run1(input logic s, input logic x, input logic y, input logic c);
    logic [65:0] m;
    int lat;
    m = model(1, s, {63'd0, x}, {63'd0, y}, c);
    @(negedge clk);
    bus1.start = 1'b1; bus1.sub = s; bus1.a = x; bus1.b = y; bus1.cin = c;
    @(negedge clk);
    bus1.start = 1'b0;
    lat = 0;
    while (!bus1.done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("lat1", lat, 1);
    check("sum1", bus1.sum, m[0]);
    check("cout1", bus1.cout, m[64]);
    check("ovf1", bus1.ovf, m[65]);
    @(negedge clk);
    check("pulse1", bus1.done, 0);
  endtask

  logic [7:0] da[5] = '{8'h5A, 8'hFF, 8'h7F, 8'h10, 8'h80};
  logic [7:0] db[5] = '{8'h3C, 8'h01, 8'h00, 8'h20, 8'h01};
  logic       ds[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic       dc[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic [7:0] es[5] = '{8'h96, 8'h00, 8'h80, 8'hF0, 8'h7F};
  logic       ec[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic       eo[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    logic [18:0] q[$];
    logic [18:0] e;
    logic [65:0] m;
    int accepts, dones, prev_done, seen;

    bus8.start = 1'b0; bus8.sub = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus1.start = 1'b0; bus1.sub = 1'b0; bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    check("rst_ready", bus8.ready, 1);
    check("rst_busy", bus8.busy, 0);
    check("rst_done", bus8.done, 0);
    check("rst_sum", bus8.sum, 0);
    check("rst_cout", bus8.cout, 0);
    check("rst_ovf", bus8.ovf, 0);
    check("rst_ready1", bus1.ready, 1);

    // Directed cases with hand-computed results
    for (int i = 0; i < 5; i++) begin
      run8(ds[i], da[i], db[i], dc[i]);
      check("dir_sum", bus8.sum, es[i]);
      check("dir_cout", bus8.cout, ec[i]);
      check("dir_ovf", bus8.ovf, eo[i]);
    end

    // start held high with operands changing every cycle
    accepts = 0; dones = 0; prev_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus8.done) begin
        dones++;
        check("hold_pulse", prev_done, 0);
        if (q.size() == 0) begin
          check("hold_queue", 0, 1);
        end else begin
          e = q.pop_front();
          m = model(8, e[18], {56'd0, e[17:10]}, {56'd0, e[9:2]}, e[1]);
          check("hold_sum", bus8.sum, m[7:0]);
          check("hold_cout", bus8.cout, m[64]);
          check("hold_ovf", bus8.ovf, m[65]);
        end
      end
      prev_done = int'(bus8.done);
      bus8.start = 1'b1;
      bus8.sub = 1'($urandom); bus8.a = 8'($urandom);
      bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
      if (bus8.ready) begin
        accepts++;
        q.push_back({bus8.sub, bus8.a, bus8.b, bus8.cin, 1'b0});
      end
    end
    @(negedge clk);
    bus8.start = 1'b0;
    check("hold_accepts", accepts, 3);
    check("hold_dones", dones, 3);

    // Reset pulse while bit 3 would be processed
    repeat (12) @(negedge clk);
    bus8.start = 1'b1; bus8.sub = 1'b0; bus8.a = 8'h11; bus8.b = 8'h22; bus8.cin = 1'b0;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_ready", bus8.ready, 1);
    check("mid_busy", bus8.busy, 0);
    check("mid_done", bus8.done, 0);
    check("mid_sum", bus8.sum, 0);
    check("mid_cout", bus8.cout, 0);
    check("mid_ovf", bus8.ovf, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus8.done) seen = 1;
    end
    check("mid_no_done", seen, 0);
    run8(1'b0, 8'h01, 8'h01, 1'b0);
    check("mid_after_sum", bus8.sum, 8'h02);

    // WIDTH=1 exhaustive
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      run1(v[3], v[2], v[1], v[0]);
    end

    // Random operations at WIDTH=8
    for (int i = 0; i < 2000; i++) begin
      run8(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
